// File: rtl/button_events_pkg.sv
// Shared definitions for the button event decoder: FSM state encoding,
// event-pulse bit positions and a small sizing helper.
package button_events_pkg;

   // FSM states of the click/double-click/long-press decoder
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      WAIT2     = 3'd2,
      PRESS2    = 3'd3,
      LONG_HELD = 3'd4
   } state_t;

   // Bit positions of the registered event-pulse vector
   localparam int EV_PRESS   = 0;
   localparam int EV_RELEASE = 1;
   localparam int EV_CLICK   = 2;
   localparam int EV_DOUBLE  = 3;
   localparam int EV_LONG    = 4;
   localparam int EV_W       = 5;

   // Larger of two integers, used to size the shared timing counter
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_events_edge_detect.sv
// Rise/fall detector on an already-synchronous level. The previous sample
// is cleared by reset, so a level that is high when reset releases is seen
// as a rising edge on the first active cycle.
module edge_detect (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_Level,
   output logic o_Rise,
   output logic o_Fall
);

   logic r_Prev;

   // Remember the level from the previous cycle
   always_ff @(posedge i_Clk) begin
      if (i_Reset) r_Prev <= 1'b0;
      else         r_Prev <= i_Level;
   end

   assign o_Rise =  i_Level & ~r_Prev;
   assign o_Fall = ~i_Level &  r_Prev;

endmodule

// File: rtl/button_events.sv
// Button event decoder: turns a debounced, synchronous button level into
// one-cycle press/release/click/double-click/long-press pulses. All outputs
// are registered, so every pulse appears one cycle after the clock edge at
// which its cause is sampled. o_State exposes the FSM state for debug.
module button_events
   import button_events_pkg::*;
#(
   parameter int LONG_PRESS_CYCLES   = 1000000,
   parameter int DOUBLE_CLICK_CYCLES = 250000
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Level,
   output logic       o_Press,
   output logic       o_Release,
   output logic       o_Click,
   output logic       o_Double_Click,
   output logic       o_Long_Press,
   output logic       o_Held,
   output logic [2:0] o_State
);

   // One spare bit above the larger threshold so saturation never aliases
   localparam int CW = $clog2(max_int(LONG_PRESS_CYCLES, DOUBLE_CLICK_CYCLES)) + 1;
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);
   localparam logic [CW-1:0] DBL_LAST  = CW'(DOUBLE_CLICK_CYCLES - 1);

   state_t          r_State, w_Next;
   logic [CW-1:0]   r_Count, w_Count, w_Count_Inc;
   logic [EV_W-1:0] r_Events, w_Events;
   logic            r_Held;
   logic            w_Rise, w_Fall;

   edge_detect u_edge (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Level (i_Level),
      .o_Rise  (w_Rise),
      .o_Fall  (w_Fall)
   );

   // Saturating increment: the counter parks at all-ones instead of wrapping
   assign w_Count_Inc = (r_Count == '1) ? r_Count : r_Count + 1'b1;

   // Next-state, next-count and event pulses for this cycle
   always_comb begin
      w_Next   = r_State;
      w_Count  = r_Count;
      w_Events = '0;
      w_Events[EV_PRESS]   = w_Rise;
      w_Events[EV_RELEASE] = w_Fall;
      case (r_State)
         IDLE: begin
            if (w_Rise) begin
               w_Next  = PRESS1;
               w_Count = '0;
            end
         end
         PRESS1: begin
            if (w_Fall) begin
               w_Next  = WAIT2;
               w_Count = '0;
            end else if (r_Count == LONG_LAST) begin
               w_Events[EV_LONG] = 1'b1;
               w_Next            = LONG_HELD;
            end else begin
               w_Count = w_Count_Inc;
            end
         end
         WAIT2: begin
            // A press on the timeout cycle still wins over the click
            if (w_Rise) begin
               w_Events[EV_DOUBLE] = 1'b1;
               w_Next              = PRESS2;
               w_Count             = '0;
            end else if (r_Count == DBL_LAST) begin
               w_Events[EV_CLICK] = 1'b1;
               w_Next             = IDLE;
               w_Count            = '0;
            end else begin
               w_Count = w_Count_Inc;
            end
         end
         PRESS2: begin
            if (w_Fall) begin
               w_Next  = IDLE;
               w_Count = '0;
            end
         end
         LONG_HELD: begin
            if (w_Fall) begin
               w_Next  = IDLE;
               w_Count = '0;
            end
         end
         default: begin
            w_Next  = IDLE;
            w_Count = '0;
         end
      endcase
   end

   // State, counter and output registers; reset drops any pending event
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_State  <= IDLE;
         r_Count  <= '0;
         r_Events <= '0;
         r_Held   <= 1'b0;
      end else begin
         r_State  <= w_Next;
         r_Count  <= w_Count;
         r_Events <= w_Events;
         r_Held   <= i_Level;
      end
   end

   assign o_Press        = r_Events[EV_PRESS];
   assign o_Release      = r_Events[EV_RELEASE];
   assign o_Click        = r_Events[EV_CLICK];
   assign o_Double_Click = r_Events[EV_DOUBLE];
   assign o_Long_Press   = r_Events[EV_LONG];
   assign o_Held         = r_Held;
   assign o_State        = r_State;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with LONG_PRESS_CYCLES=8 and
// DOUBLE_CLICK_CYCLES=6. Each step drives the level for one cycle and
// checks all outputs sampled 1 time unit after the following rising edge.
module tb_button_events;
   import button_events_pkg::*;

   // Expected event patterns {long, double, click, release, press}
   localparam logic [4:0] N = 5'b00000;
   localparam logic [4:0] P = 5'b00001;
   localparam logic [4:0] R = 5'b00010;
   localparam logic [4:0] C = 5'b00100;
   localparam logic [4:0] D = 5'b01000;
   localparam logic [4:0] L = 5'b10000;

   logic       i_Clk = 1'b0;
   logic       i_Reset;
   logic       i_Level;
   logic       o_Press, o_Release, o_Click, o_Double_Click, o_Long_Press, o_Held;
   logic [2:0] o_State;

   int vectors     = 0;
   int miscompares = 0;

   button_events #(
      .LONG_PRESS_CYCLES   (8),
      .DOUBLE_CLICK_CYCLES (6)
   ) dut (
      .i_Clk          (i_Clk),
      .i_Reset        (i_Reset),
      .i_Level        (i_Level),
      .o_Press        (o_Press),
      .o_Release      (o_Release),
      .o_Click        (o_Click),
      .o_Double_Click (o_Double_Click),
      .o_Long_Press   (o_Long_Press),
      .o_Held         (o_Held),
      .o_State        (o_State)
   );

   // Clock
   always #5 i_Clk = ~i_Clk;

   // Compare every output against {held, long, double, click, release, press}
   task automatic check(input logic [5:0] exp, input string tag);
      logic [5:0] obs;
      obs = {o_Held, o_Long_Press, o_Double_Click, o_Click, o_Release, o_Press};
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: outputs got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic check_state(input state_t exp, input string tag);
      vectors++;
      assert (o_State === exp)
      else begin
         miscompares++;
         $error("FAIL %s: state got %0d want %0d", tag, o_State, exp);
      end
   endtask

   // Drive one cycle of level and check the outputs registered at that edge
   task automatic step(input logic lvl, input logic [4:0] ev, input string tag);
      @(negedge i_Clk);
      i_Level = lvl;
      @(posedge i_Clk);
      #1;
      check({lvl, ev}, tag);
   endtask

   // One cycle with reset asserted: everything must read zero
   task automatic rstep(input logic lvl, input string tag);
      @(negedge i_Clk);
      i_Level = lvl;
      @(posedge i_Clk);
      #1;
      check(6'b000000, tag);
      check_state(IDLE, {tag, "_state"});
   endtask

   initial begin
      i_Reset = 1'b1;
      i_Level = 1'b0;
      rstep(1'b0, "reset0");
      rstep(1'b0, "reset1");
      i_Reset = 1'b0;

      // Single click: o_Click 6 cycles after o_Release
      step(1'b1, P, "clk_press");
      step(1'b1, N, "clk_hold1");
      step(1'b1, N, "clk_hold2");
      step(1'b0, R, "clk_release");
      for (int i = 0; i < 5; i++) step(1'b0, N, "clk_gap");
      step(1'b0, C, "clk_click");
      for (int i = 0; i < 3; i++) step(1'b0, N, "clk_idle");
      check_state(IDLE, "clk_end_state");

      // Double click with a short gap
      step(1'b1, P, "dbl_press1");
      step(1'b1, N, "dbl_hold1");
      step(1'b1, N, "dbl_hold1");
      step(1'b0, R, "dbl_release1");
      step(1'b0, N, "dbl_gap");
      step(1'b1, P | D, "dbl_press2");
      check_state(PRESS2, "dbl_press2_state");
      step(1'b1, N, "dbl_hold2");
      step(1'b1, N, "dbl_hold2");
      step(1'b0, R, "dbl_release2");
      check_state(IDLE, "dbl_end_state");
      for (int i = 0; i < 8; i++) step(1'b0, N, "dbl_no_click");

      // Long press: pulse 8 cycles after o_Press, once; release only
      step(1'b1, P, "long_press");
      for (int i = 0; i < 7; i++) step(1'b1, N, "long_hold");
      step(1'b1, L, "long_pulse");
      check_state(LONG_HELD, "long_state");
      for (int i = 0; i < 11; i++) step(1'b1, N, "long_held");
      step(1'b0, R, "long_release");
      for (int i = 0; i < 8; i++) step(1'b0, N, "long_no_click");

      // Release on the long threshold cycle is still a short press
      step(1'b1, P, "edge_press");
      for (int i = 0; i < 7; i++) step(1'b1, N, "edge_hold");
      step(1'b0, R, "edge_release");
      for (int i = 0; i < 5; i++) step(1'b0, N, "edge_gap");
      step(1'b0, C, "edge_click");

      // Second press exactly on the timeout cycle counts as a double click
      step(1'b1, P, "to_press1");
      step(1'b1, N, "to_hold1");
      step(1'b1, N, "to_hold1");
      step(1'b0, R, "to_release1");
      for (int i = 0; i < 5; i++) step(1'b0, N, "to_gap");
      step(1'b1, P | D, "to_press2");
      step(1'b1, N, "to_hold2");
      step(1'b0, R, "to_release2");
      for (int i = 0; i < 8; i++) step(1'b0, N, "to_no_click");

      // Reset during WAIT2 drops the click; level high through release
      step(1'b1, P, "rst_press");
      step(1'b1, N, "rst_hold");
      step(1'b1, N, "rst_hold");
      step(1'b0, R, "rst_release");
      step(1'b0, N, "rst_gap");
      step(1'b0, N, "rst_gap");
      check_state(WAIT2, "rst_wait2_state");
      i_Reset = 1'b1;
      rstep(1'b1, "rst_mid0");
      rstep(1'b1, "rst_mid1");
      rstep(1'b1, "rst_mid2");
      i_Reset = 1'b0;
      step(1'b1, P, "rst_after_press");
      check_state(PRESS1, "rst_after_state");
      step(1'b1, N, "rst_after_hold");
      step(1'b0, R, "rst_after_release");
      for (int i = 0; i < 5; i++) step(1'b0, N, "rst_after_gap");
      step(1'b0, C, "rst_after_click");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
